// File: rtl/ft245_tx_packetizer.sv
// rtl/ft245_tx_packetizer.sv - frames a 32-bit sample stream into fixed-size SYNC/payload/trailer packets
// for the FT245 TX FIFO; every packet is exactly PACKET_SIZE words.
module ft245_tx_packetizer #(
  parameter int unsigned PACKET_SIZE = 1024,
  parameter logic [31:0] SYNC_WORD   = 32'hA5A5_5A5A,
  parameter logic [31:0] PAD_WORD    = 32'h0000_0000,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        usb_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        tx_fifo_full,
  output logic [31:0] tx_fifo_data,
  output logic        tx_fifo_write,
  output logic [15:0] seq,
  output logic        busy
);

  localparam logic [10:0] CAP = 11'(PACKET_SIZE - 2);
  localparam int unsigned IW  = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_HEADER  = 5'b00010,
    S_PAYLOAD = 5'b00100,
    S_PAD     = 5'b01000,
    S_TRAILER = 5'b10000
  } state_t;

  state_t        state_q;
  logic [10:0]   cnt_q;
  logic [10:0]   len_q;
  logic [IW-1:0] idle_q;
  logic [15:0]   seq_q;
  logic          flush_pend_q;

  logic          accept;
  logic [10:0]   cnt_inc;
  logic [IW-1:0] idle_inc;

  assign accept   = (state_q == S_PAYLOAD) && s_valid && !tx_fifo_full;
  assign cnt_inc  = cnt_q + 11'd1;
  assign idle_inc = idle_q + 1'b1;
  assign seq      = seq_q;
  assign busy     = (state_q != S_IDLE);

  // Zero-latency write path: strobe and data follow the state and the live inputs.
  always_comb begin
    s_ready       = 1'b0;
    tx_fifo_write = 1'b0;
    tx_fifo_data  = '0;
    unique case (state_q)
      S_HEADER: begin
        tx_fifo_write = !tx_fifo_full;
        tx_fifo_data  = SYNC_WORD;
      end
      S_PAYLOAD: begin
        s_ready       = !tx_fifo_full;
        tx_fifo_write = s_valid && !tx_fifo_full;
        tx_fifo_data  = s_data;
      end
      S_PAD: begin
        tx_fifo_write = !tx_fifo_full;
        tx_fifo_data  = PAD_WORD;
      end
      S_TRAILER: begin
        tx_fifo_write = !tx_fifo_full;
        tx_fifo_data  = {seq_q, 5'b0, len_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge usb_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      idle_q       <= '0;
      seq_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable && s_valid) state_q <= S_HEADER;
        end
        S_HEADER: begin
          if (flush) flush_pend_q <= 1'b1;
          if (!tx_fifo_full) begin
            state_q <= S_PAYLOAD;
            cnt_q   <= '0;
            len_q   <= '0;
            idle_q  <= '0;
          end
        end
        S_PAYLOAD: begin
          if (flush) flush_pend_q <= 1'b1;
          if (accept) begin
            cnt_q  <= cnt_inc;
            len_q  <= len_q + 11'd1;
            idle_q <= '0;
          end else if (!s_valid) begin
            idle_q <= idle_inc;
          end
          // A full packet wins over a same-cycle flush: no padding is needed.
          if (accept && cnt_inc == CAP) begin
            state_q      <= S_TRAILER;
            flush_pend_q <= 1'b0;
          end else if (flush || flush_pend_q || (!s_valid && idle_inc == TMO)) begin
            state_q <= S_PAD;
          end
        end
        S_PAD: begin
          if (flush) flush_pend_q <= 1'b1;
          if (!tx_fifo_full) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CAP) begin
              state_q      <= S_TRAILER;
              flush_pend_q <= 1'b0;
            end
          end
        end
        S_TRAILER: begin
          if (!tx_fifo_full) begin
            seq_q   <= seq_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_tx_packetizer.sv
// tb/tb_ft245_tx_packetizer.sv - self-checking bench for ft245_tx_packetizer
// (PACKET_SIZE=8, TIMEOUT=10).
module tb_ft245_tx_packetizer;

  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;
  localparam logic [31:0] PAD  = 32'h0000_0000;
  localparam int CAP     = 6;
  localparam int TIMEOUT = 10;

  logic        usb_clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        tx_fifo_full = 1'b0;
  logic        s_ready;
  logic [31:0] tx_fifo_data;
  logic        tx_fifo_write;
  logic [15:0] seq;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] wr_q[$];
  int          wr_t[$];
  logic [31:0] exp_q[$];
  logic [31:0] pw[$];
  logic [31:0] offered[$];

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        full;
    logic        w;
    logic [31:0] wd;
    logic        rdy;
    logic        bsy;
  } vec_t;
  vec_t t1[14];

  ft245_tx_packetizer #(
    .PACKET_SIZE(8),
    .SYNC_WORD(SYNC),
    .PAD_WORD(PAD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .usb_clk(usb_clk),
    .rst(rst),
    .enable(enable),
    .flush(flush),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .tx_fifo_full(tx_fifo_full),
    .tx_fifo_data(tx_fifo_data),
    .tx_fifo_write(tx_fifo_write),
    .seq(seq),
    .busy(busy)
  );

  always #5 usb_clk = ~usb_clk;

  always @(posedge usb_clk) cyc <= cyc + 1;

  always @(negedge usb_clk) begin
    if (rst && tx_fifo_write) begin
      wr_q.push_back(tx_fifo_data);
      wr_t.push_back(cyc);
      checks++;
      if (tx_fifo_full) begin
        errors++;
        $display("FAIL write_while_full: write=1 with tx_fifo_full=1 at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  // Reference packet: SYNC, real words, padding up to CAP, trailer {seq,len}.
  task automatic build_pkt(input logic [15:0] sq);
    exp_q.push_back(SYNC);
    foreach (pw[i]) exp_q.push_back(pw[i]);
    for (int i = pw.size(); i < CAP; i++) exp_q.push_back(PAD);
    exp_q.push_back({sq, 16'(pw.size())});
    pw.delete();
  endtask

  task automatic cmp_stream(input string name);
    check({name, "_len"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    wr_t.delete();
    exp_q.delete();
  endtask

  task automatic send_word(input logic [31:0] d, input logic fl, input bit rnd_full);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    flush   = fl;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      if (rnd_full) tx_fifo_full = ($urandom_range(0, 2) == 0);
      @(negedge usb_clk);
      acc = s_ready;
      @(posedge usb_clk);
      #1;
      flush = 1'b0;
      n++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout: word %h not accepted in 200 cycles", d);
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int gap;
    logic [31:0] w;

    t1[0]  = '{1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    t1[1]  = '{1'b1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1};
    t1[2]  = '{1'b1, 32'd1, 1'b0, 1'b1, SYNC,  1'b0, 1'b1};
    t1[3]  = '{1'b1, 32'd1, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1};
    t1[4]  = '{1'b1, 32'd2, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1};
    t1[5]  = '{1'b1, 32'd2, 1'b0, 1'b1, 32'd2, 1'b1, 1'b1};
    t1[6]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1};
    t1[7]  = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd3, 1'b1, 1'b1};
    t1[8]  = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd4, 1'b1, 1'b1};
    t1[9]  = '{1'b1, 32'd5, 1'b0, 1'b1, 32'd5, 1'b1, 1'b1};
    t1[10] = '{1'b1, 32'd6, 1'b0, 1'b1, 32'd6, 1'b1, 1'b1};
    t1[11] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1};
    t1[12] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b1};
    t1[13] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};

    // Reset state
    repeat (3) tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_write", 32'(tx_fifo_write), 32'd0);
    check("rst_data", tx_fifo_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq", 32'(seq), 32'd0);
    rst = 1'b1;
    enable = 1'b1;
    tick();

    // Full packet with stalls, cycle by cycle
    for (int i = 0; i < 14; i++) begin
      s_valid = t1[i].v;
      s_data = t1[i].d;
      tx_fifo_full = t1[i].full;
      @(negedge usb_clk);
      check($sformatf("t1_write[%0d]", i), 32'(tx_fifo_write), 32'(t1[i].w));
      check($sformatf("t1_ready[%0d]", i), 32'(s_ready), 32'(t1[i].rdy));
      check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(t1[i].bsy));
      if (t1[i].w) check($sformatf("t1_data[%0d]", i), tx_fifo_data, t1[i].wd);
      @(posedge usb_clk);
      #1;
    end
    s_valid = 1'b0;
    tx_fifo_full = 1'b0;
    check("t1_seq", 32'(seq), 32'd1);
    wr_q.delete();
    wr_t.delete();

    // Timeout flush after two words
    send_word(32'h101, 1'b0, 1'b0);
    send_word(32'h102, 1'b0, 1'b0);
    wait_idle(100);
    if (wr_t.size() >= 4) check("t2_timeout_gap", 32'(wr_t[3] - wr_t[2]), 32'(TIMEOUT + 1));
    else check("t2_write_count", 32'(wr_t.size()), 32'd8);
    pw.push_back(32'h101);
    pw.push_back(32'h102);
    build_pkt(16'd1);
    cmp_stream("t2");

    // Flush on the cycle of the third word; flush in IDLE ignored
    send_word(32'h201, 1'b0, 1'b0);
    send_word(32'h202, 1'b0, 1'b0);
    send_word(32'h203, 1'b1, 1'b0);
    wait_idle(100);
    pw.push_back(32'h201);
    pw.push_back(32'h202);
    pw.push_back(32'h203);
    build_pkt(16'd2);
    cmp_stream("t3");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    check("t3_idle_flush_writes", 32'(wr_q.size()), 32'd0);
    check("t3_idle_flush_busy", 32'(busy), 32'd0);
    wr_q.delete();
    wr_t.delete();

    // Sequence wrap
    force dut.seq_q = 16'hFFFF;
    #1;
    release dut.seq_q;
    #1;
    check("t5_seq_forced", 32'(seq), 32'h0000_FFFF);
    send_word(32'h0AA, 1'b0, 1'b0);
    wait_idle(100);
    pw.push_back(32'h0AA);
    build_pkt(16'hFFFF);
    send_word(32'h0BB, 1'b0, 1'b0);
    wait_idle(100);
    pw.push_back(32'h0BB);
    build_pkt(16'h0000);
    cmp_stream("t5");
    check("t5_seq_after_wrap", 32'(seq), 32'd1);

    // Reset in the middle of PAYLOAD
    send_word(32'h061, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data = 32'h062;
    #2;
    check("t6_write_before_rst", 32'(tx_fifo_write), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_ready", 32'(s_ready), 32'd0);
    check("t6_rst_write", 32'(tx_fifo_write), 32'd0);
    check("t6_rst_data", tx_fifo_data, 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_seq", 32'(seq), 32'd0);
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    wr_q.delete();
    wr_t.delete();
    for (int i = 1; i <= CAP; i++) begin
      send_word(32'h070 + 32'(i), 1'b0, 1'b0);
      pw.push_back(32'h070 + 32'(i));
    end
    wait_idle(100);
    build_pkt(16'd0);
    cmp_stream("t6");

    // Random FIFO back-pressure over several packets
    k = 5;
    for (int i = 0; i < k * CAP; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        tx_fifo_full = ($urandom_range(0, 2) == 0);
        tick();
      end
      w = $urandom;
      offered.push_back(w);
      send_word(w, 1'b0, 1'b1);
    end
    for (int n = 0; n < 500 && busy; n++) begin
      tx_fifo_full = ($urandom_range(0, 2) == 0);
      tick();
    end
    tx_fifo_full = 1'b0;
    wait_idle(100);
    for (int p = 0; p < k; p++) begin
      for (int j = 0; j < CAP; j++) pw.push_back(offered[p * CAP + j]);
      build_pkt(16'(1 + p));
    end
    cmp_stream("t4");
    check("t4_seq", 32'(seq), 32'(1 + k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
